sha256_multiblock_core: RTL and testbench

//  Runtime-length SHA-256 engine: reads an N-word message from shared word memory, pads it in hardware,

---
 rtl/sha256_multiblock_core.sv | 219 +++++++++++++++++++++
 tb/tb_sha256_multiblock_core.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_multiblock_core.sv
// Runtime-length SHA-256 engine: reads N words, pads in hardware, hashes every block, writes the digest.
// Optional SHA-224 mode is compiled in when SHA256_SHA224_EN is defined (adds the sha224 input).
module sha256_multiblock_core #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       num_words,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
`ifdef SHA256_SHA224_EN
    input  logic              sha224,
`endif
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_COMPUTE, S_UPDATE, S_WRITE} state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

`ifdef SHA256_SHA224_EN
    localparam logic [31:0] IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t            state_q;
    logic              done_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [6:0]        cnt_q;
    logic [15:0]       blk_q;
    logic [15:0]       n_q;
    logic [ADDR_W-1:0] msg_q;
    logic [ADDR_W-1:0] out_q;
    logic [2:0]        wr_last_q;
    logic [31:0]       hv_q [0:7];
    logic [31:0]       wv_q [0:7];
    logic [31:0]       w_q  [0:15];

    logic [15:0] n_clamp;
    logic [15:0] n_blocks;
    logic [15:0] rd_g;
    logic [15:0] nx_g;
    logic [15:0] nb_g;
    logic [3:0]  j_idx;
    logic        last_blk;
    logic [31:0] w_word;
    logic [31:0] iv_sel [0:7];
    logic [2:0]  wr_last_sel;
    logic [31:0] s0, s1, big0, big1, ch, maj, t1, t2;
    logic [31:0] w_d, a_d, e_d;

    always_comb begin
        n_clamp  = (num_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : num_words;
        n_blocks = (n_q + 16'd18) >> 4;
        j_idx    = cnt_q[3:0] - 4'd1;
        rd_g     = 16'(blk_q << 4) + 16'(cnt_q) - 16'd1;
        nx_g     = 16'(blk_q << 4) + 16'(cnt_q) + 16'd1;
        nb_g     = 16'((blk_q + 16'd1) << 4);
        last_blk = ((blk_q + 16'd1) == n_blocks);
        // The final two words of the last block carry the bit length; padding never reaches them.
        if (last_blk && j_idx == 4'd14)      w_word = '0;
        else if (last_blk && j_idx == 4'd15) w_word = 32'(n_q) << 5;
        else if (rd_g < n_q)                 w_word = mem_read_data;
        else if (rd_g == n_q)                w_word = 32'h8000_0000;
        else                                 w_word = '0;

        iv_sel      = IV256;
        wr_last_sel = 3'd7;
`ifdef SHA256_SHA224_EN
        if (sha224) begin
            iv_sel      = IV224;
            wr_last_sel = 3'd6;
        end
`endif
    end

    // Window holds W[t..t+15]; slot 0 feeds the current round, slot 15 receives W[t+16].
    always_comb begin
        s0   = rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3);
        s1   = rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10);
        w_d  = s1 + w_q[9] + s0 + w_q[0];
        big1 = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
        big0 = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
        ch   = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
        maj  = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
        t1   = wv_q[7] + big1 + ch + K[cnt_q[5:0]] + w_q[0];
        t2   = big0 + maj;
        a_d  = t1 + t2;
        e_d  = wv_q[3] + t1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            blk_q     <= '0;
            n_q       <= '0;
            msg_q     <= '0;
            out_q     <= '0;
            wr_last_q <= 3'd7;
            for (int i = 0; i < 8; i++) begin
                hv_q[i] <= '0;
                wv_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= n_clamp;
                        msg_q     <= message_addr;
                        out_q     <= output_addr;
                        wr_last_q <= wr_last_sel;
                        blk_q     <= '0;
                        cnt_q     <= '0;
                        hv_q      <= iv_sel;
                        if (n_clamp != 16'd0) addr_q <= message_addr;
                        done_q    <= 1'b0;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt_q != 7'd0) w_q[j_idx] <= w_word;
                    if (cnt_q <= 7'd14 && nx_g < n_q) addr_q <= msg_q + ADDR_W'(nx_g);
                    if (cnt_q == 7'd16) begin
                        cnt_q   <= '0;
                        wv_q    <= hv_q;
                        state_q <= S_COMPUTE;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_COMPUTE: begin
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_d;
                    wv_q[0] <= a_d;
                    wv_q[1] <= wv_q[0];
                    wv_q[2] <= wv_q[1];
                    wv_q[3] <= wv_q[2];
                    wv_q[4] <= e_d;
                    wv_q[5] <= wv_q[4];
                    wv_q[6] <= wv_q[5];
                    wv_q[7] <= wv_q[6];
                    if (cnt_q == 7'd63) begin
                        cnt_q   <= '0;
                        state_q <= S_UPDATE;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) hv_q[i] <= hv_q[i] + wv_q[i];
                    blk_q <= blk_q + 16'd1;
                    if (last_blk) begin
                        state_q <= S_WRITE;
                    end else begin
                        if (nb_g < n_q) addr_q <= msg_q + ADDR_W'(nb_g);
                        state_q <= S_READ;
                    end
                end
                S_WRITE: begin
                    // First WRITE cycle only registers word 0, so the strobe trails the state by one cycle.
                    if (cnt_q <= 7'(wr_last_q)) begin
                        we_q    <= 1'b1;
                        addr_q  <= out_q + ADDR_W'(cnt_q);
                        wdata_q <= hv_q[cnt_q[2:0]];
                        cnt_q   <= cnt_q + 7'd1;
                    end else begin
                        we_q    <= 1'b0;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Directed bench for sha256_multiblock_core: known digests, a reference SHA-256 model, latency and memory-traffic checks.
// The SHA-224 case is included when SHA256_SHA224_EN is defined.
module tb_sha256_multiblock_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic [15:0] message_addr = '0;
    logic [15:0] output_addr = '0;
    logic        sha_sel = 1'b0;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;

    logic [31:0] mem [0:65535];
    logic [31:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int rd_count = 0;
    int wr_count = 0;
    int job_n = 0;
    logic [15:0] job_base = '0;
    logic [15:0] out_base = '0;
    logic [15:0] prev_addr = '0;
    int lat;

    localparam logic [31:0] MK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_multiblock_core dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_words     (num_words),
        .message_addr  (message_addr),
        .output_addr   (output_addr),
`ifdef SHA256_SHA224_EN
        .sha224        (sha_sel),
`endif
        .done          (done),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    // Clock and synchronous word memory (read data one cycle after the address).
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Traffic monitor: every new read address must lie in the message, writes must walk the digest area in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                check("wr_addr", {16'b0, mem_addr}, {16'b0, out_base + 16'(wr_count)});
                wr_count++;
            end else if (!done && mem_addr != prev_addr) begin
                check("rd_range", {31'b0, (16'(mem_addr - job_base) < 16'(job_n))}, 32'd1);
                rd_count++;
            end
            prev_addr = mem_addr;
        end
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 of n words starting at base (wrapping), digest pushed onto exp_q.
    task automatic model_push(input logic [15:0] base, input int n);
        logic [31:0] hh [0:7];
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        int nb;
        hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        nb = (n + 1 + 2 + 15) / 16;
        for (int blk = 0; blk < nb; blk++) begin
            for (int t = 0; t < 16; t++) begin
                int idx;
                idx = blk * 16 + t;
                if (idx < n)       w[t] = mem[base + 16'(idx)];
                else if (idx == n) w[t] = 32'h8000_0000;
                else               w[t] = 32'h0;
            end
            if (blk == nb - 1) w[15] = 32'(n * 32);
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
            e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
            for (int t = 0; t < 64; t++) begin
                t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + MK[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1;
                d = c; c = b; b = a; a = t1 + t2;
            end
            hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
            hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(hh[i]);
    endtask

    task automatic push8(input logic [255:0] dig);
        for (int i = 7; i >= 0; i--) exp_q.push_back(dig[i*32 +: 32]);
    endtask

    // Drives a start request (called just after a clock edge) and returns after the sampling edge.
    task automatic begin_job(input int n, input logic [15:0] maddr, input logic [15:0] oaddr, input logic sha);
        for (int i = 0; i < 9; i++) mem[oaddr + 16'(i)] = 32'hdeadbeef;
        job_base = maddr;
        job_n = (n > 64) ? 64 : n;
        out_base = oaddr;
        rd_count = 0;
        wr_count = 0;
        num_words = 16'(n);
        message_addr = maddr;
        output_addr = oaddr;
        sha_sel = sha;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("done_drop", {31'b0, done}, 32'd0);
    endtask

    task automatic scramble_inputs();
        start = 1'b0;
        num_words = 16'($urandom_range(0, 65535));
        message_addr = 16'($urandom_range(0, 65535));
        output_addr = 16'($urandom_range(0, 65535));
        sha_sel = 1'($urandom_range(0, 1));
    endtask

    // Counts edges from the sampling edge until done is seen high; optionally pulses start mid-job.
    task automatic wait_done(output int cycles, input int pulse_at);
        cycles = 0;
        while (!done && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == pulse_at) start = 1'b1;
            else if (cycles == pulse_at + 1) start = 1'b0;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_job(input string tag, input int cycles, input int exp_lat, input int nwr);
        check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
        for (int i = 0; i < nwr; i++)
            check($sformatf("%s_h%0d", tag, i), mem[out_base + 16'(i)], exp_q.pop_front());
        check({tag, "_tail"}, mem[out_base + 16'(nwr)], 32'hdeadbeef);
        check({tag, "_nwr"}, 32'(wr_count), 32'(nwr));
        check({tag, "_nrd"}, 32'(rd_count), 32'(job_n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 14; i++)
            mem[16'h0200 + 16'(i)] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
        for (int i = 0; i < 20; i++) mem[16'h0300 + 16'(i)] = $urandom;
        for (int i = 0; i < 64; i++) mem[16'h1000 + 16'(i)] = $urandom;
        mem[16'hFFFE] = 32'h01234567;
        mem[16'hFFFF] = 32'h89abcdef;
        mem[16'h0000] = 32'hfedcba98;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'b0, done}, 32'd1);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", {16'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty message
        push8(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
        begin_job(0, 16'h0200, 16'h0100, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("n0", lat, 91, 8);

        // "abcd"
        push8(256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589);
        begin_job(1, 16'h0200, 16'h0110, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("n1", lat, 91, 8);

        // 56-byte "abcdbcde...nopq": length word spills into a second block
        push8(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
        begin_job(14, 16'h0200, 16'h0120, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("n14", lat, 173, 8);

        // Two full-ish blocks, with a start pulse during COMPUTE that must be ignored
        model_push(16'h0300, 20);
        begin_job(20, 16'h0300, 16'h0130, 1'b0);
        scramble_inputs();
        wait_done(lat, 40);
        finish_job("n20", lat, 173, 8);

        // Message address wraps past 0xFFFF
        model_push(16'hFFFE, 3);
        begin_job(3, 16'hFFFE, 16'h0140, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("wrap", lat, 91, 8);

        // Oversized length clamps to 64 words (5 blocks)
        model_push(16'h1000, 64);
        begin_job(100, 16'h1000, 16'h0180, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("clamp", lat, 419, 8);

        // Back-to-back: start held high, second job samples in the first IDLE cycle
        push8(256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589);
        push8(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
        begin_job(1, 16'h0200, 16'h0150, 1'b0);
        num_words = 16'd0;
        output_addr = 16'h0160;
        wait_done(lat, -1);
        finish_job("b2b_a", lat, 91, 8);
        begin_job(0, 16'h0200, 16'h0160, 1'b0);
        scramble_inputs();
        wait_done(lat, -1);
        finish_job("b2b_b", lat, 91, 8);

        // Asynchronous reset in the middle of COMPUTE
        begin_job(20, 16'h0300, 16'h0170, 1'b0);
        scramble_inputs();
        repeat (30) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_done", {31'b0, done}, 32'd1);
        check("abort_we", {31'b0, mem_we}, 32'd0);
        check("abort_addr", {16'b0, mem_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push8(256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589);
        begin_job(1, 16'h0200, 16'h0190, 1'b0);
        scramble_inputs();
        sha_sel = 1'b0;
        wait_done(lat, -1);
        finish_job("recover", lat, 91, 8);

`ifdef SHA256_SHA224_EN
        // SHA-224 of the empty message: seven words, eighth slot untouched
        push8(256'hd14a028c_2a3a2bc9_476102bb_288234c4_15a2b01f_828ea62a_c5b3e42f_00000000);
        void'(exp_q.pop_back());
        begin_job(0, 16'h0200, 16'h01a0, 1'b1);
        start = 1'b0;
        wait_done(lat, -1);
        finish_job("sha224", lat, 90, 7);
        sha_sel = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
